fp_sum_sequencer: RTL and testbench

Initiator-side controller for the pipelined `FloatAdder`. It accepts a stream of IEEE-754 single-precision operands over a valid/ready interface and issues one add per operand to the adder, driving `Op1`/`Op2`/`InputValid` and consuming `Result`/`ResultValid`. It folds each result into a running accumulator and reports the final sum of N operands. It sits between operand producers (e.g. memory readers) and a single `FloatAdder` instance.

---
 rtl/fp_sum_sequencer.sv | 121 ++++++++++++
 tb/tb_fp_sum_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_sum_sequencer: accumulates N floats through one external FloatAdder.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fp_sum_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic [31:0]      InData,
    input  logic             InValid,
    output logic             InReady,
    output logic [31:0]      AddOp1,
    output logic [31:0]      AddOp2,
    output logic             AddInputValid,
    input  logic [31:0]      AddResult,
    input  logic             AddResultValid,
    output logic [31:0]      Sum,
    output logic             SumValid,
    output logic             Busy,
    output logic             Error
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        op_q, op_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    acc_d   = '0;
                    rem_d   = Count;
                    err_d   = 1'b0;
                    state_d = (Count != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (InValid) begin
                    op_d    = InData;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final count still wins over the timeout.
                if (AddResultValid) begin
                    acc_d   = AddResult;
                    state_d = (rem_q != '0) ? S_FETCH : S_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign InReady       = (state_q == S_FETCH);
    assign AddInputValid = (state_q == S_ISSUE);
    assign SumValid      = (state_q == S_DONE);
    assign Busy          = (state_q != S_IDLE);
    assign AddOp1        = acc_q;
    assign AddOp2        = op_q;
    assign Sum           = acc_q;
    assign Error         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_sum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_sum_sequencer: directed bench with a 5-stage table-driven adder.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fp_sum_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] Count = '0;
    logic [31:0] InData = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] AddOp1, AddOp2, AddResult, Sum;
    logic        AddInputValid, AddResultValid, SumValid, Busy, Error;

    logic        adder_on  = 1'b1;
    logic        stray_rv  = 1'b0;
    logic [31:0] stray_val = '0;

    int checks = 0;
    int errors = 0;

    fp_sum_sequencer #(.CNT_W(16), .TIMEOUT(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Count(Count),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .AddOp1(AddOp1), .AddOp2(AddOp2), .AddInputValid(AddInputValid),
        .AddResult(AddResult), .AddResultValid(AddResultValid),
        .Sum(Sum), .SumValid(SumValid), .Busy(Busy), .Error(Error)
    );

    always #5 Clock = ~Clock;

    // Adder stand-in: only the operand pairs used by the directed tests are known.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h0000_0000, 32'h3F80_0000}: fadd = 32'h3F80_0000;
            {32'h3F80_0000, 32'h4000_0000}: fadd = 32'h4040_0000;
            {32'h4040_0000, 32'h4040_0000}: fadd = 32'h40C0_0000;
            {32'h3F80_0000, 32'hBF80_0000}: fadd = 32'h0000_0000;
            {32'h0000_0000, 32'h4000_0000}: fadd = 32'h4000_0000;
            {32'h0000_0000, 32'h4040_0000}: fadd = 32'h4040_0000;
            default:                        fadd = 32'hFFFF_FFFF;
        endcase
    endfunction

    logic [4:0]  pv = '0;
    logic [31:0] pr [5];
    logic [31:0] last_op1 = '0, last_op2 = '0;
    int          issue_cnt = 0;
    int          sv_cnt = 0;

    always @(posedge Clock) begin
        pv    <= {pv[3:0], AddInputValid & adder_on};
        pr[0] <= fadd(AddOp1, AddOp2);
        for (int i = 1; i < 5; i++) pr[i] <= pr[i-1];
        if (AddInputValid) begin
            issue_cnt <= issue_cnt + 1;
            last_op1  <= AddOp1;
            last_op2  <= AddOp2;
        end
        if (SumValid) sv_cnt <= sv_cnt + 1;
    end

    assign AddResultValid = pv[4] | stray_rv;
    assign AddResult      = stray_rv ? stray_val : pr[4];

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic feed(input logic [31:0] v, output bit ok);
        int n = 0;
        InData  = v;
        InValid = 1'b1;
        while (!InReady && n < 200) begin
            tick();
            n++;
        end
        ok = InReady;
        tick();
        InValid = 1'b0;
    endtask

    task automatic wait_sum(output bit ok);
        int n = 0;
        while (!SumValid && n < 200) begin
            tick();
            n++;
        end
        ok = SumValid;
    endtask

    task automatic start(input logic [15:0] n);
        Start = 1'b1;
        Count = n;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if ({InReady, AddInputValid, SumValid, Busy, Error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {InReady, AddInputValid, SumValid, Busy, Error});
        end
        checks++;
        if ({AddOp1, AddOp2, Sum} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want zeros", AddOp1, AddOp2, Sum);
        end
    endtask

    task automatic test_basic;
        bit ok0, ok1, ok2, oks;
        int base = issue_cnt;
        start(16'd3);
        checks++;
        if (InReady !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_fetch_c1: InReady=%b Busy=%b want 1 1", InReady, Busy);
        end
        feed(32'h3F80_0000, ok0);
        feed(32'h4000_0000, ok1);
        feed(32'h4040_0000, ok2);
        wait_sum(oks);
        checks++;
        if (!(ok0 && ok1 && ok2 && oks)) begin
            errors++;
            $display("FAIL basic_progress: got %b%b%b%b want 1111", ok0, ok1, ok2, oks);
        end
        checks++;
        if (Sum !== 32'h40C0_0000) begin
            errors++;
            $display("FAIL basic_sum: got %h want 40c00000", Sum);
        end
        tick();
        checks++;
        if (SumValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: SumValid=%b Busy=%b want 0 0", SumValid, Busy);
        end
        checks++;
        if (issue_cnt - base !== 3) begin
            errors++;
            $display("FAIL basic_issues: got %0d want 3", issue_cnt - base);
        end
    endtask

    task automatic test_zero_count;
        int base = issue_cnt;
        start(16'd0);
        checks++;
        if (SumValid !== 1'b1 || Sum !== 32'h0) begin
            errors++;
            $display("FAIL zero_done: SumValid=%b Sum=%h want 1 00000000", SumValid, Sum);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || issue_cnt - base !== 0) begin
            errors++;
            $display("FAIL zero_idle: Busy=%b issues=%0d want 0 0", Busy, issue_cnt - base);
        end
    endtask

    task automatic test_cancel;
        bit ok0, ok1, oks;
        start(16'd2);
        feed(32'h3F80_0000, ok0);
        feed(32'hBF80_0000, ok1);
        wait_sum(oks);
        checks++;
        if (!(ok0 && ok1 && oks) || Sum !== 32'h0) begin
            errors++;
            $display("FAIL cancel_sum: got %h ok=%b%b%b want 00000000 ok=111", Sum, ok0, ok1, oks);
        end
        checks++;
        if (last_op1 !== 32'h3F80_0000 || last_op2 !== 32'hBF80_0000) begin
            errors++;
            $display("FAIL cancel_ops: got %h %h want 3f800000 bf800000", last_op1, last_op2);
        end
        tick();
    endtask

    task automatic test_backpressure;
        bit all_ok = 1'b1;
        bit ok0, oks;
        int base = issue_cnt;
        int sv_base;
        start(16'd1);
        for (int i = 0; i < 10; i++) begin
            if (InReady !== 1'b1 || AddInputValid !== 1'b0) all_ok = 1'b0;
            tick();
        end
        checks++;
        if (!all_ok || issue_cnt - base !== 0) begin
            errors++;
            $display("FAIL stall: ready_ok=%b issues=%0d want 1 0", all_ok, issue_cnt - base);
        end
        stray_val = 32'hDEAD_BEEF;
        stray_rv  = 1'b1;
        tick();
        stray_rv  = 1'b0;
        checks++;
        if (AddOp1 !== 32'h0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL stray_result: Acc=%h InReady=%b want 00000000 1", AddOp1, InReady);
        end
        start(16'd5);
        sv_base = sv_cnt;
        feed(32'h4000_0000, ok0);
        wait_sum(oks);
        checks++;
        if (!(ok0 && oks) || Sum !== 32'h4000_0000 || issue_cnt - base !== 1) begin
            errors++;
            $display("FAIL start_busy: Sum=%h issues=%0d ok=%b%b want 40000000 1 11",
                     Sum, issue_cnt - base, ok0, oks);
        end
        tick();
        checks++;
        if (sv_cnt - sv_base !== 1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_end: pulses=%0d Busy=%b want 1 0", sv_cnt - sv_base, Busy);
        end
    endtask

    task automatic test_timeout;
        bit ok0;
        int n = 0;
        int sv_base = sv_cnt;
        adder_on = 1'b0;
        start(16'd1);
        feed(32'h3F80_0000, ok0);
        while (Busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b0 || n != 18) begin
            errors++;
            $display("FAIL timeout: Error=%b Busy=%b cycles=%0d want 1 0 18", Error, Busy, n);
        end
        checks++;
        if (sv_cnt != sv_base || Sum !== 32'h0) begin
            errors++;
            $display("FAIL timeout_nosum: pulses=%0d Sum=%h want 0 00000000", sv_cnt - sv_base, Sum);
        end
        tick();
        checks++;
        if (Error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b want 1", Error);
        end
        adder_on = 1'b1;
        start(16'd0);
        checks++;
        if (Error !== 1'b0 || SumValid !== 1'b1) begin
            errors++;
            $display("FAIL error_clear: Error=%b SumValid=%b want 0 1", Error, SumValid);
        end
        tick();
    endtask

    task automatic test_reset_wait;
        bit ok0;
        start(16'd1);
        feed(32'h4040_0000, ok0);
        tick();
        checks++;
        if (!ok0 || AddOp2 !== 32'h4040_0000 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rwait_setup: Op2=%h Busy=%b want 40400000 1", AddOp2, Busy);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({InReady, AddInputValid, SumValid, Busy, Error} !== 5'b0 ||
            {AddOp1, AddOp2, Sum} !== 96'h0) begin
            errors++;
            $display("FAIL rwait_reset: ctrl=%b Op1=%h Op2=%h Sum=%h want zeros",
                     {InReady, AddInputValid, SumValid, Busy, Error}, AddOp1, AddOp2, Sum);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (Sum !== 32'h0 || Busy !== 1'b0 || SumValid !== 1'b0) begin
            errors++;
            $display("FAIL rwait_late: Sum=%h Busy=%b SumValid=%b want 00000000 0 0", Sum, Busy, SumValid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_cancel();
        test_backpressure();
        test_timeout();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
